// File: rtl/demux1x2_stream32.sv
// rtl/demux1x2_stream32.sv - registered 1-to-2 stream demux; optional per-channel word counters via DEMUX_WORD_COUNT_EN
module demux1x2_stream32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             selection,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Each channel is a one-entry register; its valid bit is the EMPTY/FULL state.
    logic             y0_valid_q, y0_valid_d;
    logic             y1_valid_q, y1_valid_d;
    logic [WIDTH-1:0] y0_q, y0_d;
    logic [WIDTH-1:0] y1_q, y1_d;

    logic can_take0, can_take1;
    logic take0, take1;
    logic out_fire0, out_fire1;

    // Handshake decode: a channel can accept when empty or draining this cycle.
    always_comb begin
        can_take0 = !y0_valid_q || y0_ready;
        can_take1 = !y1_valid_q || y1_ready;
        a_ready   = selection ? can_take1 : can_take0;
        take0     = a_valid && a_ready && !selection;
        take1     = a_valid && a_ready &&  selection;
        out_fire0 = y0_valid_q && y0_ready;
        out_fire1 = y1_valid_q && y1_ready;
    end

    // State register: channel valids and held words, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y0_valid_q <= 1'b0;
            y1_valid_q <= 1'b0;
            y0_q       <= '0;
            y1_q       <= '0;
        end else begin
            y0_valid_q <= y0_valid_d;
            y1_valid_q <= y1_valid_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
        end
    end

    // Next state: a new word wins over a drain, so fill+drain keeps the channel full.
    always_comb begin
        y0_d       = y0_q;
        y1_d       = y1_q;
        y0_valid_d = y0_valid_q;
        y1_valid_d = y1_valid_q;
        if (take0) begin
            y0_d       = a;
            y0_valid_d = 1'b1;
        end else if (out_fire0) begin
            y0_valid_d = 1'b0;
        end
        if (take1) begin
            y1_d       = a;
            y1_valid_d = 1'b1;
        end else if (out_fire1) begin
            y1_valid_d = 1'b0;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        y0       = y0_q;
        y1       = y1_q;
        y0_valid = y0_valid_q;
        y1_valid = y1_valid_q;
    end

`ifdef DEMUX_WORD_COUNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Delivered-word counters, wrapping freely; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (out_fire0) cnt0_q <= cnt0_q + CNT_W'(1);
            if (out_fire1) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: doc/demux1x2_stream32.md
Name: demux1x2_stream32

Overview:
- Registered 1-to-2 demultiplexer for 32-bit words; the distributing counterpart of the 2-to-1 selector in the datapath library.
- Accepts one word per cycle on a valid/ready input with a select bit and routes it to output channel 0 or 1.
- Each channel has its own one-entry output register with valid/ready, so a stalled channel never blocks traffic bound for the other.
- Sits between a single producer and two independent consumers (e.g. two processing lanes).

Parameters:
- WIDTH, 32, data width of input and both outputs.
- CNT_W, 16, width of per-channel word counters (used only with the optional feature).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  input data word.
- selection  input  1  destination of the word: 0 -> channel 0, 1 -> channel 1.
- a_valid  input  1  word and selection valid.
- a_ready  output  1  block accepts the word this cycle.
- y0  output  WIDTH  channel 0 data (registered).
- y0_valid  output  1  channel 0 holds a word.
- y0_ready  input  1  channel 0 consumer takes the word.
- y1  output  WIDTH  channel 1 data (registered).
- y1_valid  output  1  channel 1 holds a word.
- y1_ready  input  1  channel 1 consumer takes the word.
- cnt0  output  CNT_W  words delivered on channel 0 (optional feature only).
- cnt1  output  CNT_W  words delivered on channel 1 (optional feature only).

Behaviour:
- Reset (asynchronous, active-high): y0/y1 = 0; y0_valid/y1_valid = 0; cnt0/cnt1 = 0. a_ready is combinational and evaluates to 1 once both channels are empty.
- Per channel k, two states: EMPTY (yk_valid=0) and FULL (yk_valid=1).
- can_take_k = !yk_valid | yk_ready.
- a_ready = selection ? can_take_1 : can_take_0. Combinational from selection, yk_valid and yk_ready; no dependency on a_valid.
- Input transfer: a_valid & a_ready at a rising edge.
  - The word is written to yk, with k = selection.
  - yk_valid = 1 from the next cycle.
  - Latency from input transfer to output valid: exactly 1 cycle.
- Output transfer on channel k: yk_valid & yk_ready.
  - If no new word targets k in the same cycle, yk_valid goes to 0 and yk holds its last value.
- Simultaneous output transfer on k and input transfer to k: yk loads the new word and yk_valid stays 1. Full throughput is 1 word/cycle per channel.
- Input transfer to channel k never alters channel 1-k's register or valid.
- Stalled channel (yk_valid=1, yk_ready=0):
  - Input words with selection=k see a_ready=0.
  - The producer must hold a, selection and a_valid stable until accepted.
  - Words for the other channel still flow.
- Once yk_valid=1, yk is stable until the output transfer on that channel.
- selection is sampled only with an input transfer. When a_valid=0, no register changes except output draining.
- Reset mid-operation: all buffered words are discarded and valids clear immediately. There is no replay.

Optional Feature:
- Macro: DEMUX_WORD_COUNT_EN.
- Defined:
  - cnt0/cnt1 increment by 1 on each output transfer of their channel.
  - They wrap modulo 2^CNT_W: all-ones to 0, no saturation and no flag.
  - They are cleared only by rst.
- Not defined:
  - cnt0/cnt1 are tied to 0.
  - No counter registers are synthesized.
- Port list is identical in both cases.

Test Plan:
- Reset then idle:
  - Assert rst asynchronously mid-cycle -> y0_valid=y1_valid=0 and y0=y1=0 immediately.
  - After release with a_valid=0 -> a_ready=1.
- Basic routing:
  - Send a=32'hDEADBEEF with selection=0, then a=32'h12345678 with selection=1, both consumers ready.
  - Required: y0=DEADBEEF with y0_valid one cycle after its transfer.
  - Required: y1=12345678 with y1_valid one cycle after its transfer.
  - Required: the other channel's valid stays 0 in each case.
- Back-to-back throughput: 8 consecutive words 0..7, alternating selection, both ready=1 -> a_ready=1 every cycle, and each channel delivers its 4 words in order, one per transfer.
- Channel stall isolation:
  - Hold y0_ready=0 with channel 0 full.
  - Offer selection=0, a=32'hAAAA0000 -> a_ready=0 and y0 is unchanged.
  - Then offer selection=1, a=32'h5555FFFF -> accepted, and y1 updates next cycle.
- Simultaneous drain/fill and reset mid-stall:
  - y0 full, y0_ready=1, new selection=0 word in the same cycle -> y0_valid stays 1 and y0 takes the new word.
  - Assert rst while y1 is stalled full -> y1_valid=0 and the word is dropped.
- DEMUX_WORD_COUNT_EN wrap:
  - With CNT_W=4, deliver 17 words on channel 1 -> cnt1=1 and cnt0=0.
  - Without the macro -> cnt0=cnt1=0 throughout.
